// File: rtl/bf16_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : bf16_mul_pipe
//  Brief    : 3-stage pipelined bfloat16 multiplier with valid/ready flow
//             control and a frame-boundary (last) tag carried per product.
//             S1 decode, S2 mantissa multiply, S3 normalize/round/pack.
//  Options  : BF16_MUL_RNE_EN - defined: round-to-nearest-even,
//                               undefined: truncate (guard/sticky dropped).
//  Revision : 1.0 - initial release
// ============================================================================
module bf16_mul_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic [1:0]  occupancy
);

  // Result class decided at decode; anything but NUM bypasses the arithmetic.
  localparam logic [1:0] KIND_NUM  = 2'd0;
  localparam logic [1:0] KIND_ZERO = 2'd1;
  localparam logic [1:0] KIND_INF  = 2'd2;
  localparam logic [1:0] KIND_NAN  = 2'd3;
  localparam logic [9:0] BIAS      = 10'd127;

`ifdef BF16_MUL_RNE_EN
  localparam logic RNE_EN = 1'b1;
`else
  localparam logic RNE_EN = 1'b0;
`endif

  logic              w_en;
  logic [1:0]        w_occ_next;
  logic              r_s1_valid, r_s2_valid, r_s3_valid;
  logic              r_s1_last, r_s2_last;
  logic              r_s1_sign, r_s2_sign;
  logic [1:0]        r_s1_kind, r_s2_kind;
  logic signed [9:0] r_s1_exp, r_s2_exp;
  logic [6:0]        r_s1_ma, r_s1_mb;
  logic [15:0]       r_s2_prod;
  logic [15:0]       w_prod;

  // Whole pipe advances together whenever the output slot is free or draining.
  assign w_en       = !r_s3_valid || out_ready;
  assign in_ready   = w_en;
  assign out_valid  = r_s3_valid;
  assign w_occ_next = {1'b0, in_valid} + {1'b0, r_s1_valid} + {1'b0, r_s2_valid};

  logic [7:0]        w_ea, w_eb;
  logic [6:0]        w_ma, w_mb;
  logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [1:0]        w_kind;
  logic signed [9:0] w_exp_sum;

  // Operand decode: classify inputs (denormals treated as zero) and bias exponents.
  always_comb begin
    w_ea      = in_a[14:7];
    w_eb      = in_b[14:7];
    w_ma      = in_a[6:0];
    w_mb      = in_b[6:0];
    w_a_zero  = (w_ea == 8'h00);
    w_b_zero  = (w_eb == 8'h00);
    w_a_inf   = (w_ea == 8'hFF) && (w_ma == 7'h00);
    w_b_inf   = (w_eb == 8'hFF) && (w_mb == 7'h00);
    w_a_nan   = (w_ea == 8'hFF) && (w_ma != 7'h00);
    w_b_nan   = (w_eb == 8'hFF) && (w_mb != 7'h00);
    w_exp_sum = $signed({2'b00, w_ea} + {2'b00, w_eb} - BIAS);
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
      w_kind = KIND_NAN;
    else if (w_a_inf || w_b_inf)
      w_kind = KIND_INF;
    else if (w_a_zero || w_b_zero)
      w_kind = KIND_ZERO;
    else
      w_kind = KIND_NUM;
  end

  assign w_prod = {8'd0, 1'b1, r_s1_ma} * {8'd0, 1'b1, r_s1_mb};

  logic              w_hi, w_guard, w_sticky, w_round_up;
  logic [6:0]        w_mant;
  logic [7:0]        w_mant_rnd;
  logic signed [9:0] w_exp_norm, w_exp_fin;
  logic [15:0]       w_result;

  // Normalize, round and pack the S2 product, or select a special result.
  always_comb begin
    w_hi = r_s2_prod[15];
    if (w_hi) begin
      w_mant   = r_s2_prod[14:8];
      w_guard  = r_s2_prod[7];
      w_sticky = |r_s2_prod[6:0];
    end else begin
      w_mant   = r_s2_prod[13:7];
      w_guard  = r_s2_prod[6];
      w_sticky = |r_s2_prod[5:0];
    end
    w_exp_norm = r_s2_exp + (w_hi ? 10'sd1 : 10'sd0);
    w_round_up = RNE_EN & w_guard & (w_sticky | w_mant[0]);
    w_mant_rnd = {1'b0, w_mant} + {7'd0, w_round_up};
    // Carry out of the mantissa leaves the 7 stored bits at zero, bump exponent.
    w_exp_fin  = w_exp_norm + (w_mant_rnd[7] ? 10'sd1 : 10'sd0);
    case (r_s2_kind)
      KIND_NAN:  w_result = 16'h7FC0;
      KIND_INF:  w_result = {r_s2_sign, 8'hFF, 7'h00};
      KIND_ZERO: w_result = {r_s2_sign, 15'h0000};
      default: begin
        if (w_exp_fin >= 10'sd255)
          w_result = {r_s2_sign, 8'hFF, 7'h00};
        else if (w_exp_fin <= 10'sd0)
          w_result = {r_s2_sign, 15'h0000};
        else
          w_result = {r_s2_sign, w_exp_fin[7:0], w_mant_rnd[6:0]};
      end
    endcase
  end

  // Control state: valid/last chain, output register and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s2_last  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= 16'h0000;
      occupancy  <= 2'd0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
      r_s1_last  <= in_valid & in_last;
      r_s2_last  <= r_s1_last;
      occupancy  <= w_occ_next;
      if (r_s2_valid) begin
        out_data <= w_result;
        out_last <= r_s2_last;
      end
    end
  end

  // Datapath registers for S1/S2; only loaded when a valid entry moves in.
  always_ff @(posedge clk) begin
    if (w_en && in_valid) begin
      r_s1_sign <= in_a[15] ^ in_b[15];
      r_s1_kind <= w_kind;
      r_s1_exp  <= w_exp_sum;
      r_s1_ma   <= w_ma;
      r_s1_mb   <= w_mb;
    end
    if (w_en && r_s1_valid) begin
      r_s2_sign <= r_s1_sign;
      r_s2_kind <= r_s1_kind;
      r_s2_exp  <= r_s1_exp;
      r_s2_prod <= w_prod;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bf16_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bf16_mul_pipe
//  Brief    : Self-checking bench for bf16_mul_pipe (vector table, scoreboard,
//             backpressure, random stall stream, async reset mid-flight).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bf16_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic [1:0]  occupancy;

  bf16_mul_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

`ifdef BF16_MUL_RNE_EN
  localparam logic [15:0] EXP_3FC1_SQ = 16'h4012;
`else
  localparam logic [15:0] EXP_3FC1_SQ = 16'h4011;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        last;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } sb_t;

  sb_t         q[$];
  logic [15:0] cur_exp;
  int          tests;
  int          fails;
  int          n_pops;

  // Independent reference: integer multiply with explicit remainder rounding.
  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int   ea, eb, ma, mb, e, prod, sh, m8;
    logic s;
    logic an, bn, ai, bi;
    s  = a[15] ^ b[15];
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    ma = int'(a[6:0]);
    mb = int'(b[6:0]);
    an = (ea == 255) && (ma != 0);
    bn = (eb == 255) && (mb != 0);
    ai = (ea == 255) && (ma == 0);
    bi = (eb == 255) && (mb == 0);
    if (an || bn || (ai && eb == 0) || (bi && ea == 0)) return 16'h7FC0;
    if (ai || bi) return {s, 8'hFF, 7'h00};
    if (ea == 0 || eb == 0) return {s, 15'h0000};
    prod = (128 + ma) * (128 + mb);
    e    = ea + eb - 127;
    if (prod >= 32768) begin
      sh = 8;
      e  = e + 1;
    end else begin
      sh = 7;
    end
    m8 = prod >> sh;
`ifdef BF16_MUL_RNE_EN
    begin
      int rem, half;
      rem  = prod % (1 << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (m8 % 2) == 1)) m8 = m8 + 1;
      if (m8 == 256) begin
        m8 = 128;
        e  = e + 1;
      end
    end
`endif
    if (e >= 255) return {s, 8'hFF, 7'h00};
    if (e <= 0) return {s, 15'h0000};
    return {s, 8'(e), 7'(m8 - 128)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // One clock: sample handshakes at negedge, score outputs, then return #1 after posedge.
  task automatic step(output logic acc);
    sb_t e;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      n_pops++;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL stale_output: got out_data=%h out_last=%b, expected no product", out_data, out_last);
      end else begin
        e = q.pop_front();
        if (out_data !== e.data || out_last !== e.last) begin
          fails++;
          $display("FAIL product: got out_data=%h out_last=%b, expected %h %b", out_data, out_last, e.data, e.last);
        end
      end
    end
    if (acc) q.push_back('{data: cur_exp, last: in_last});
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max_cycles);
    logic acc;
    int   n;
    n = 0;
    while (q.size() != 0 && n < max_cycles) begin
      step(acc);
      n++;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    vec_t tbl[13];
    logic acc;
    int   n;
    int   pops0;

    tbl[0]  = '{16'h3FC0, 16'h4000, 1'b0, 16'h4040};
    tbl[1]  = '{16'h3FC1, 16'h3FC1, 1'b1, EXP_3FC1_SQ};
    tbl[2]  = '{16'h7F80, 16'h0000, 1'b0, 16'h7FC0};
    tbl[3]  = '{16'hFF80, 16'h4000, 1'b0, 16'hFF80};
    tbl[4]  = '{16'h7F00, 16'h4000, 1'b1, 16'h7F80};
    tbl[5]  = '{16'h0080, 16'h3F00, 1'b0, 16'h0000};
    tbl[6]  = '{16'h7FC1, 16'h3F80, 1'b0, 16'h7FC0};
    tbl[7]  = '{16'hBF80, 16'h4040, 1'b1, 16'hC040};
    tbl[8]  = '{16'h8000, 16'h4000, 1'b0, 16'h8000};
    tbl[9]  = '{16'h0001, 16'h4000, 1'b0, 16'h0000};
    tbl[10] = '{16'h3F80, 16'h3F80, 1'b0, 16'h3F80};
    tbl[11] = '{16'hC000, 16'hC000, 1'b0, 16'h4080};
    tbl[12] = '{16'hFF80, 16'h8000, 1'b1, 16'h7FC0};

    tests     = 0;
    fails     = 0;
    n_pops    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 16'h0000;
    in_b      = 16'h0000;
    in_last   = 1'b0;
    out_ready = 1'b0;
    cur_exp   = 16'h0000;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'h0000);
    check("reset_out_last", 32'(out_last), 32'd0);
    check("reset_occupancy", 32'(occupancy), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: product visible after the third edge counted from acceptance.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 16'h3FC0;
    in_b      = 16'h4000;
    in_last   = 1'b1;
    cur_exp   = 16'h4040;
    step(acc);
    check("latency_accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    step(acc);
    check("latency_not_early", 32'(out_valid), 32'd0);
    step(acc);
    check("latency_valid", 32'(out_valid), 32'd1);
    check("latency_data", 32'(out_data), 32'h4040);
    check("latency_last", 32'(out_last), 32'd1);
    drain(10);

    // Vector table, back-to-back.
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1;
      in_a     = tbl[i].a;
      in_b     = tbl[i].b;
      in_last  = tbl[i].last;
      cur_exp  = tbl[i].exp;
      n = 0;
      do begin
        step(acc);
        n++;
      end while (!acc && n < 20);
      check("table_accept", 32'(acc), 32'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    drain(20);

    // Backpressure: fill three stages, stall, then release.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a     = 16'h3F80 + 16'(i);
      in_b     = 16'h4000 + 16'(i * 3);
      in_last  = (i == 2);
      cur_exp  = ref_mul(in_a, in_b);
      step(acc);
      check("bp_fill_accept", 32'(acc), 32'd1);
    end
    check("bp_occupancy", 32'(occupancy), 32'd3);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    in_a    = 16'h3F83;
    in_b    = 16'h4009;
    in_last = 1'b0;
    cur_exp = ref_mul(in_a, in_b);
    for (int k = 0; k < 3; k++) begin
      step(acc);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_out_data_hold", 32'(out_data), 32'(ref_mul(16'h3F80, 16'h4000)));
    end
    pops0     = n_pops;
    out_ready = 1'b1;
    step(acc);
    check("bp_accept4", 32'(acc), 32'd1);
    in_a    = 16'h3F84;
    in_b    = 16'h400C;
    in_last = 1'b1;
    cur_exp = ref_mul(in_a, in_b);
    step(acc);
    check("bp_accept5", 32'(acc), 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (3) step(acc);
    check("bp_drain_count", 32'(n_pops - pops0), 32'd5);
    check("bp_queue_empty", 32'(q.size()), 32'd0);

    // Random out_ready stream of 8 pairs; only the 8th carries last.
    begin
      int i;
      i = 0;
      n = 0;
      while (i < 8 && n < 200) begin
        in_valid  = 1'b1;
        in_a      = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 7'($urandom)};
        in_b      = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 7'($urandom)};
        in_last   = (i == 7);
        cur_exp   = ref_mul(in_a, in_b);
        out_ready = 1'($urandom_range(0, 1));
        step(acc);
        n++;
        while (!acc && n < 200) begin
          out_ready = 1'($urandom_range(0, 1));
          step(acc);
          n++;
        end
        if (acc) i++;
      end
      check("rand_all_accepted", 32'(i), 32'd8);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    drain(20);

    // Asynchronous reset with three entries in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a     = 16'h4040 + 16'(i);
      in_b     = 16'h3FA0;
      in_last  = 1'b0;
      cur_exp  = ref_mul(in_a, in_b);
      step(acc);
    end
    in_valid = 1'b0;
    check("rst_pre_occupancy", 32'(occupancy), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_out_valid", 32'(out_valid), 32'd0);
    check("rst_async_occupancy", 32'(occupancy), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (6) step(acc);
    check("rst_no_stale_valid", 32'(out_valid), 32'd0);
    check("rst_no_stale_occ", 32'(occupancy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
